// File: rtl/cond_pkg.sv
// Shared constants for the conditional-execution logic: ARM condition
// encodings, NZCV bit positions and FlagW bit meanings.
package cond_pkg;

  // ARM condition field encodings
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Bit positions inside a {N,Z,C,V} flag nibble
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // FlagW bit meanings
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_logic_banked_cond_check.sv
// Pure combinational ARM condition evaluator. Kept standalone so hazard
// logic can evaluate conditions against forwarded or predicted flags.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_true
);

  logic n_flag;
  logic z_flag;
  logic c_flag;
  logic v_flag;

  assign n_flag = flags[FLAG_N];
  assign z_flag = flags[FLAG_Z];
  assign c_flag = flags[FLAG_C];
  assign v_flag = flags[FLAG_V];

  // Decode the condition field against the supplied flags
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_EQ: cond_true = z_flag;
      COND_NE: cond_true = ~z_flag;
      COND_CS: cond_true = c_flag;
      COND_CC: cond_true = ~c_flag;
      COND_MI: cond_true = n_flag;
      COND_PL: cond_true = ~n_flag;
      COND_VS: cond_true = v_flag;
      COND_VC: cond_true = ~v_flag;
      COND_HI: cond_true = c_flag & ~z_flag;
      COND_LS: cond_true = ~c_flag | z_flag;
      COND_GE: cond_true = (n_flag == v_flag);
      COND_LT: cond_true = (n_flag != v_flag);
      COND_GT: cond_true = ~z_flag & (n_flag == v_flag);
      COND_LE: cond_true = z_flag | (n_flag != v_flag);
      COND_AL: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic_banked.sv
// Banked NZCV conditional-execution unit. Holds NUM_BANKS flag banks and a
// shadow register, gates PC/register/memory write enables on the condition
// of the active bank, and optionally registers the enables for a pipelined
// write-back stage.
module cond_logic_banked
  import cond_pkg::*;
#(
  parameter int NUM_BANKS = 2,
  parameter int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  parameter int REG_OUT   = 0
) (
  input  logic              CLK,
  input  logic              nReset,
  input  logic              InstrValid,
  input  logic [3:0]        Cond,
  input  logic [3:0]        ALUFlags,
  input  logic [1:0]        FlagW,
  input  logic              PCS,
  input  logic              RegW,
  input  logic              MemW,
  input  logic [BANK_W-1:0] BankSel,
  input  logic              Save,
  input  logic              Restore,
  output logic              PCSrc,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic              CondEx,
  output logic [3:0]        Flags,
  output logic [3:0]        SavedFlags
);

  // One past the highest legal bank index, in BankSel width plus one bit
  localparam logic [BANK_W:0] BANK_LIMIT = (BANK_W + 1)'(NUM_BANKS);

  logic [3:0]        bank_view [NUM_BANKS];
  logic [3:0]        shadow_reg;
  logic [BANK_W-1:0] sel_eff;
  logic [3:0]        active_flags;
  logic              cond_true;
  logic              condex_raw;
  logic              nz_we;
  logic              cv_we;
  logic [3:0]        en_comb;

  // Out-of-range selects alias onto bank 0 for both reads and writes
  assign sel_eff      = ({1'b0, BankSel} < BANK_LIMIT) ? BankSel : '0;
  assign active_flags = bank_view[sel_eff];

  cond_check u_cond_check (
    .cond      (Cond),
    .flags     (active_flags),
    .cond_true (cond_true)
  );

  // Holding reset masks the instruction so no enable or flag write escapes
  assign condex_raw = nReset & InstrValid & cond_true;
  assign nz_we      = FlagW[FLAGW_NZ] & condex_raw;
  assign cv_we      = FlagW[FLAGW_CV] & condex_raw;
  assign en_comb    = {condex_raw, PCS & condex_raw, RegW & condex_raw, MemW & condex_raw};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic       hit;
      logic [3:0] bank_reg;
      logic [3:0] bank_next;

      assign hit           = (sel_eff == BANK_W'(gi));
      assign bank_view[gi] = bank_reg;

      // Next value of this bank: restore overrides any ALU flag write
      always_comb begin
        bank_next = bank_reg;
        if (hit) begin
          if (Restore) begin
            bank_next = shadow_reg;
          end else begin
            if (nz_we) bank_next[3:2] = ALUFlags[3:2];
            if (cv_we) bank_next[1:0] = ALUFlags[1:0];
          end
        end
      end

      // Bank storage, cleared by reset
      always_ff @(posedge CLK) begin
        if (!nReset) bank_reg <= '0;
        else         bank_reg <= bank_next;
      end
    end
  endgenerate

  // Shadow captures the pre-edge active bank, so a same-cycle flag write is excluded
  always_ff @(posedge CLK) begin
    if (!nReset)   shadow_reg <= '0;
    else if (Save) shadow_reg <= active_flags;
  end

  assign Flags      = active_flags;
  assign SavedFlags = shadow_reg;

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [3:0] en_reg;

      // Delay the enables one cycle for the write-back stage; reset drops pending ones
      always_ff @(posedge CLK) begin
        if (!nReset) en_reg <= '0;
        else         en_reg <= en_comb;
      end

      assign {CondEx, PCSrc, RegWrite, MemWrite} = en_reg;
    end else begin : g_comb_out
      assign {CondEx, PCSrc, RegWrite, MemWrite} = en_comb;
    end
  endgenerate

endmodule

// File: tb/tb_cond_logic_banked.sv
// Scoreboard bench for cond_logic_banked: a combinational-output instance and
// a registered-output instance share the same stimulus. Each stimulus cycle
// pushes its expectations; a negedge monitor pops and compares.
module tb_cond_logic_banked;

  localparam int M_EN = 1;
  localparam int M_FL = 2;
  localparam int M_SV = 4;
  localparam int M_R  = 8;

  logic       clk = 1'b0;
  logic       nreset;
  logic       instr_valid;
  logic [3:0] cond;
  logic [3:0] alu_flags;
  logic [1:0] flag_w;
  logic       pcs;
  logic       reg_w;
  logic       mem_w;
  logic [0:0] bank_sel;
  logic       save;
  logic       restore;

  logic       pcsrc_c, regwrite_c, memwrite_c, condex_c;
  logic [3:0] flags_c, saved_c;
  logic       pcsrc_r, regwrite_r, memwrite_r, condex_r;
  logic [3:0] flags_r, saved_r;

  int n_checks = 0;
  int n_fail   = 0;

  string      name_q [$];
  int         mask_q [$];
  logic [3:0] en_q   [$];
  logic [3:0] fl_q   [$];
  logic [3:0] sv_q   [$];
  logic [3:0] r_q    [$];

  always #5 clk = ~clk;

  cond_logic_banked #(.NUM_BANKS(2), .REG_OUT(0)) dut (
    .CLK(clk), .nReset(nreset), .InstrValid(instr_valid), .Cond(cond),
    .ALUFlags(alu_flags), .FlagW(flag_w), .PCS(pcs), .RegW(reg_w), .MemW(mem_w),
    .BankSel(bank_sel), .Save(save), .Restore(restore),
    .PCSrc(pcsrc_c), .RegWrite(regwrite_c), .MemWrite(memwrite_c), .CondEx(condex_c),
    .Flags(flags_c), .SavedFlags(saved_c)
  );

  cond_logic_banked #(.NUM_BANKS(2), .REG_OUT(1)) dut_r (
    .CLK(clk), .nReset(nreset), .InstrValid(instr_valid), .Cond(cond),
    .ALUFlags(alu_flags), .FlagW(flag_w), .PCS(pcs), .RegW(reg_w), .MemW(mem_w),
    .BankSel(bank_sel), .Save(save), .Restore(restore),
    .PCSrc(pcsrc_r), .RegWrite(regwrite_r), .MemWrite(memwrite_r), .CondEx(condex_r),
    .Flags(flags_r), .SavedFlags(saved_r)
  );

  // Independent reference for the condition table
  function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // en/r vectors are {CondEx, PCSrc, RegWrite, MemWrite}
  task automatic push(input string nm, input int mask, input logic [3:0] en,
                      input logic [3:0] fl, input logic [3:0] sv, input logic [3:0] r);
    name_q.push_back(nm);
    mask_q.push_back(mask);
    en_q.push_back(en);
    fl_q.push_back(fl);
    sv_q.push_back(sv);
    r_q.push_back(r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the oldest expectation against the outputs mid-cycle
  always @(negedge clk) begin : monitor
    string      nm;
    int         mask;
    logic [3:0] e_en, e_fl, e_sv, e_r, a_en, a_r;
    if (name_q.size() > 0) begin
      nm   = name_q.pop_front();
      mask = mask_q.pop_front();
      e_en = en_q.pop_front();
      e_fl = fl_q.pop_front();
      e_sv = sv_q.pop_front();
      e_r  = r_q.pop_front();
      a_en = {condex_c, pcsrc_c, regwrite_c, memwrite_c};
      a_r  = {condex_r, pcsrc_r, regwrite_r, memwrite_r};
      if ((mask & M_EN) != 0) begin
        n_checks++;
        if (a_en !== e_en) begin
          n_fail++;
          $display("FAIL %s enables {CondEx,PCSrc,RegWrite,MemWrite}: got %b expected %b", nm, a_en, e_en);
        end
      end
      if ((mask & M_FL) != 0) begin
        n_checks++;
        if (flags_c !== e_fl) begin
          n_fail++;
          $display("FAIL %s Flags: got %b expected %b", nm, flags_c, e_fl);
        end
      end
      if ((mask & M_SV) != 0) begin
        n_checks++;
        if (saved_c !== e_sv) begin
          n_fail++;
          $display("FAIL %s SavedFlags: got %b expected %b", nm, saved_c, e_sv);
        end
      end
      if ((mask & M_R) != 0) begin
        n_checks++;
        if (a_r !== e_r) begin
          n_fail++;
          $display("FAIL %s registered enables: got %b expected %b", nm, a_r, e_r);
        end
      end
      $display("txn %s: en=%b flags=%b saved=%b reg_en=%b", nm, a_en, flags_c, saved_c, a_r);
    end
  end

  initial begin
    nreset = 1'b0; instr_valid = 1'b1; cond = 4'b1110; alu_flags = 4'b0000;
    flag_w = 2'b00; pcs = 1'b0; reg_w = 1'b1; mem_w = 1'b0; bank_sel = 1'b0;
    save = 1'b0; restore = 1'b0;
    tick();

    // Reset held two cycles: enables forced low, registered enables cleared
    push("rst0", M_EN | M_R, 4'b0000, 4'b0000, 4'b0000, 4'b0000); tick();
    push("rst1", M_EN | M_R, 4'b0000, 4'b0000, 4'b0000, 4'b0000); tick();

    nreset = 1'b1; reg_w = 1'b0; alu_flags = 4'b0011; flag_w = 2'b11;
    push("al_write", M_EN | M_FL | M_SV | M_R, 4'b1000, 4'b0000, 4'b0000, 4'b0000); tick();
    cond = 4'b0001; flag_w = 2'b00;
    push("ne_after", M_EN | M_FL | M_R, 4'b1000, 4'b0011, 4'b0000, 4'b1000); tick();

    // Split NZ-only write
    cond = 4'b1110; alu_flags = 4'b0100; flag_w = 2'b10;
    push("nz_write", M_EN | M_FL, 4'b1000, 4'b0011, 4'b0000, 4'b0000); tick();
    cond = 4'b0000; flag_w = 2'b00; pcs = 1'b1;
    push("eq_pcs", M_EN | M_FL, 4'b1100, 4'b0111, 4'b0000, 4'b0000); tick();
    cond = 4'b1110; pcs = 1'b0; alu_flags = 4'b0100; flag_w = 2'b11;
    push("hold_0111", M_EN | M_FL | M_R, 4'b1000, 4'b0111, 4'b0000, 4'b1100); tick();

    // Failed condition and bubble: nothing enabled, flags untouched
    cond = 4'b0001; reg_w = 1'b1; mem_w = 1'b1; alu_flags = 4'b1000; flag_w = 2'b11;
    push("ne_fail", M_EN | M_FL, 4'b0000, 4'b0100, 4'b0000, 4'b0000); tick();
    instr_valid = 1'b0; cond = 4'b1110; pcs = 1'b1; alu_flags = 4'b1111;
    push("bubble", M_EN | M_FL, 4'b0000, 4'b0100, 4'b0000, 4'b0000); tick();
    instr_valid = 1'b1; pcs = 1'b0; reg_w = 1'b0; mem_w = 1'b0; alu_flags = 4'b1001;
    push("set_b0", M_EN | M_FL, 4'b1000, 4'b0100, 4'b0000, 4'b0000); tick();

    // Banks, save, restore priority, swap
    bank_sel = 1'b1; alu_flags = 4'b0110;
    push("set_b1", M_EN | M_FL, 4'b1000, 4'b0000, 4'b0000, 4'b0000); tick();
    bank_sel = 1'b0; flag_w = 2'b00; save = 1'b1;
    push("save_b0", M_FL | M_SV, 4'b0000, 4'b1001, 4'b0000, 4'b0000); tick();
    save = 1'b0; restore = 1'b1; flag_w = 2'b11; alu_flags = 4'b0000;
    push("restore_w", M_EN | M_FL | M_SV, 4'b1000, 4'b1001, 4'b1001, 4'b0000); tick();
    restore = 1'b0; flag_w = 2'b00;
    push("restore_prio", M_FL | M_SV, 4'b0000, 4'b1001, 4'b1001, 4'b0000); tick();
    bank_sel = 1'b1; save = 1'b1; restore = 1'b1;
    push("swap", M_FL | M_SV, 4'b0000, 4'b0110, 4'b1001, 4'b0000); tick();
    save = 1'b0; restore = 1'b0;
    push("swap_done", M_FL | M_SV, 4'b0000, 4'b1001, 4'b0110, 4'b0000); tick();
    bank_sel = 1'b0;
    push("b0_intact", M_EN | M_FL | M_SV, 4'b1000, 4'b1001, 4'b0110, 4'b0000); tick();

    // Registered outputs: one-cycle delay, then reset discards the pending enable
    reg_w = 1'b1;
    push("reg_t", M_EN | M_R, 4'b1010, 4'b0000, 4'b0000, 4'b1000); tick();
    reg_w = 1'b0; nreset = 1'b0;
    push("reg_t1", M_EN | M_R, 4'b0000, 4'b0000, 4'b0000, 4'b1010); tick();
    nreset = 1'b1;
    push("reg_t2", M_EN | M_FL | M_SV | M_R, 4'b1000, 4'b0000, 4'b0000, 4'b0000); tick();

    // Sweep: load flags with AL, then evaluate each condition on them
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        cond = 4'b1110; flag_w = 2'b11; alu_flags = 4'(f);
        tick();
        cond = 4'(c); flag_w = 2'b00;
        push($sformatf("sweep c=%h f=%h", c, f), M_EN | M_FL,
             {cond_model(4'(c), 4'(f)), 3'b000}, 4'(f), 4'b0000, 4'b0000);
        tick();
      end
    end

    for (int i = 0; i < 5 && name_q.size() > 0; i++) @(posedge clk);
    n_checks++;
    if (name_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", name_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cond_logic_banked.md
# cond_logic_banked

Parametrised successor to the single-bank conditional logic of the ARM calculator datapath. It holds NUM_BANKS NZCV flag banks plus one shadow (saved-flags) register and evaluates the 4-bit ARM condition field against the active bank. It gates PC/register/memory write enables, and supports split NZ/CV flag writes, save/restore of flags, and an optional registered-output mode for a pipelined write-back stage. It sits between the decoder and the ALU/register-file/PC-mux.

## Interface
Parameters:
- NUM_BANKS, 2: number of NZCV flag banks; legal values are 1..16.
- BANK_W, max(1, $clog2(NUM_BANKS)): width of BankSel.
- REG_OUT, 0: 0 gives combinational enables; 1 registers PCSrc/RegWrite/MemWrite/CondEx by one cycle.

Ports:
- CLK in 1: single clock; all state updates on rising edge.
- nReset in 1: reset, synchronous, active-low.
- InstrValid in 1: current inputs describe a real instruction; 0 = bubble.
- Cond in 4: ARM condition field.
- ALUFlags in 4: {N,Z,C,V} from the ALU.
- FlagW in 2: bit1 writes N,Z; bit0 writes C,V.
- PCS, RegW, MemW in 1: decoder's unconditional intents.
- BankSel in BANK_W: active bank index.
- Save in 1: copy the active bank to the shadow register.
- Restore in 1: copy the shadow register to the active bank.
- PCSrc, RegWrite, MemWrite, CondEx out 1: gated enables and condition result.
- Flags out 4: active bank contents.
- SavedFlags out 4: shadow register.

## Operation
- Flag order is {N,Z,C,V} = [3:0].
- Conditions:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C.
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 NV 0.
- Conditions are evaluated on the current (pre-edge) contents of bank[BankSel].
- CondEx_raw = InstrValid & cond_true.
- Enables: PCSrc = PCS&CondEx_raw; RegWrite = RegW&CondEx_raw; MemWrite = MemW&CondEx_raw.
- Flag write at the edge: for the active bank, NZ <- ALUFlags[3:2] if FlagW[1]&CondEx_raw; CV <- ALUFlags[1:0] if FlagW[0]&CondEx_raw. Other banks are untouched.
- Save: shadow <- pre-edge bank[BankSel]; the flag write applied in the same cycle is not included.
- Restore: bank[BankSel] <- pre-edge shadow. Restore has priority over the FlagW write in the same cycle.
- Save & Restore together perform a swap: shadow gets the old active bank, and the active bank gets the old shadow.
- Save/Restore act regardless of InstrValid/CondEx.
- BankSel ≥ NUM_BANKS: treated as bank 0, for both reads and writes.
- Reset (nReset=0 at edge): all banks and shadow cleared to 0000; registered outputs cleared to 0.
- While nReset=0, combinational PCSrc/RegWrite/MemWrite/CondEx are forced to 0 and Save/Restore/FlagW are ignored.

## Timing
- REG_OUT=0: enables and CondEx are valid in the same cycle as their inputs (zero latency).
- REG_OUT=1: enables and CondEx appear one cycle later; reset value is 0.
- Flag update latency is 1 cycle in both modes: an instruction at cycle t sees flags written by the instruction at t-1.
- There is no flag forwarding. An instruction sees only flags already registered.
- Flags and SavedFlags are register outputs. They change only at edges and read 0000 from the cycle after reset.
- Changing BankSel changes Flags and condition evaluation combinationally, in the same cycle.
- Reset asserted mid-operation discards any pending registered enables: the next cycle shows 0.

## Structure
- Package cond_pkg holds:
  - localparams COND_EQ..COND_NV;
  - flag indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - FLAGW_NZ=1, FLAGW_CV=0.
- Sub-module cond_check: pure combinational (Cond[3:0], Flags[3:0]) -> cond_true. It is reused by later pipeline hazard logic.
- Top level contains: the bank array, shadow register, write/priority logic, and the REG_OUT generate branch.

## Test plan
- Reset then compare: nReset=0 for 2 cycles, release; Cond=1110, ALUFlags=0011, FlagW=11, RegW=0 -> CondEx=1, RegWrite=0, Flags=0011 next cycle. Then Cond=0001 (NE) -> CondEx=1.
- Split write: bank0=0011; Cond=1110, ALUFlags=0100, FlagW=10 -> Flags=0111. Next Cond=0000 (EQ), FlagW=00, PCS=1 -> PCSrc=1, Flags stay 0111.
- Failed condition: Flags=0100, Cond=0001, FlagW=11, RegW=1, MemW=1, ALUFlags=1000 -> CondEx=0, RegWrite=0, MemWrite=0, Flags unchanged at 0100. InstrValid=0 with Cond=1110 -> all enables 0.
- Banks, save/restore: bank0=1001, BankSel=1 write 0110 -> bank0 still 1001. BankSel=0, Save -> SavedFlags=1001. Restore+FlagW(11, ALUFlags=0000, AL) same cycle -> Flags=1001. Save+Restore with shadow=1001 and bank1=0110 -> swap to bank1=1001, shadow=0110.
- REG_OUT=1: Cond=1110, RegW=1 at cycle t -> RegWrite=1 at t+1 only. Assert nReset=0 at t+1 -> RegWrite=0 at t+2, Flags=0000.
- Sweep: all 16 Cond values × 16 flag values -> CondEx matches the condition list above; 1111 is always 0.
